// File: rtl/dispatch_pkg.sv
// Shared types for the dispatch controller: data-FSM states, command bytes, load regions.
// Pure declarations; no timing or flow control of its own.
package dispatch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_LOAD,
        S_CHECK,
        S_INCR,
        S_HASH
    } state_t;

    localparam logic [7:0] CMD_LOAD_ALL = 8'h01;
    localparam logic [7:0] CMD_LOAD_R0  = 8'h02;
    localparam logic [7:0] CMD_LOAD_R1  = 8'h04;
    localparam logic [7:0] CMD_LOAD_R2  = 8'h08;
    localparam logic [7:0] CMD_LOAD_R3  = 8'h10;
    localparam logic [7:0] CMD_LOAD_R4  = 8'h20;
    localparam logic [7:0] CMD_LOAD_R5  = 8'h40;
    localparam logic [7:0] CMD_ABORT    = 8'h80;

    typedef struct packed {
        logic       valid;
        logic [6:0] start_addr;
        logic [6:0] final_addr;
    } region_t;

    function automatic region_t cmd_region(input logic [7:0] cmd);
        region_t r;
        r       = '0;
        r.valid = 1'b1;
        case (cmd)
            CMD_LOAD_ALL: begin r.start_addr = 7'd0;  r.final_addr = 7'd79; end
            CMD_LOAD_R0:  begin r.start_addr = 7'd0;  r.final_addr = 7'd3;  end
            CMD_LOAD_R1:  begin r.start_addr = 7'd4;  r.final_addr = 7'd7;  end
            CMD_LOAD_R2:  begin r.start_addr = 7'd8;  r.final_addr = 7'd11; end
            CMD_LOAD_R3:  begin r.start_addr = 7'd12; r.final_addr = 7'd43; end
            CMD_LOAD_R4:  begin r.start_addr = 7'd44; r.final_addr = 7'd75; end
            CMD_LOAD_R5:  begin r.start_addr = 7'd76; r.final_addr = 7'd79; end
            default:      r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic cmd_known(input logic [7:0] cmd);
        case (cmd)
            CMD_LOAD_ALL, CMD_LOAD_R0, CMD_LOAD_R1, CMD_LOAD_R2,
            CMD_LOAD_R3, CMD_LOAD_R4, CMD_LOAD_R5, CMD_ABORT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_slot.sv
// Per-core bookkeeping: running flag, completion flag and registered start pulse.
// start_hash follows i_start by one cycle; a done pulse on an idle core is dropped.
module core_slot (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_done,
    input  logic i_clear,
    output logic o_running,
    output logic o_done,
    output logic o_start_hash
);

    logic r_running;
    logic r_done;
    logic r_start_hash;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_start_hash <= 1'b0;
        end else begin
            r_start_hash <= i_start;
            if (i_start) begin
                r_running <= 1'b1;
            end else if (i_done) begin
                r_running <= 1'b0;
            end
            // A fresh completion wins over clearing the one being reported.
            if (i_done && r_running) begin
                r_done <= 1'b1;
            end else if (i_clear) begin
                r_done <= 1'b0;
            end
        end
    end

    assign o_running    = r_running;
    assign o_done       = r_done;
    assign o_start_hash = r_start_hash;

endmodule

// File: rtl/main_dispatch_ctrl.sv
// Loads command-selected address regions into block memory, then queues hash requests onto idle cores.
// start_hash one cycle after HASH when a core is idle; overflowing requests are dropped with cmd_error.
module main_dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter  int ADDR_W    = 7,
    parameter  int NUM_CORES = 2,
    parameter  int CMD_W     = 8,
    localparam int NC_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_notify,
    input  logic [CMD_W-1:0]     rx_command,
    input  logic [NUM_CORES-1:0] hash_done,
    output logic [ADDR_W-1:0]    address,
    output logic                 load,
    output logic [NUM_CORES-1:0] start_hash,
    output logic                 nonce_ready,
    output logic [NC_W-1:0]      nonce_core,
    output logic                 cmd_error,
    output logic                 busy
);

    localparam int PEND_W = $clog2(NUM_CORES + 1);

    state_t              r_state;
    logic [CMD_W-1:0]    r_cmd;
    logic [ADDR_W-1:0]   r_address;
    logic [ADDR_W-1:0]   r_final_addr;
    logic                r_load;
    logic                r_cmd_error;
    logic [PEND_W-1:0]   r_pending;

    logic [7:0]          w_rx8;
    logic [7:0]          w_cmd8;
    logic                w_rx_ok;
    logic                w_cmd_fits;
    region_t             w_region;
    logic                w_abort;
    logic                w_full;
    logic                w_accept;
    logic                w_dispatch;
    logic [NUM_CORES-1:0] w_running;
    logic [NUM_CORES-1:0] w_done;
    logic [NUM_CORES-1:0] w_first_idle;
    logic [NUM_CORES-1:0] w_first_done;
    logic [NUM_CORES-1:0] w_start_sel;
    logic [NC_W-1:0]      w_nonce_idx;

    // Commands wider than a byte are only recognised when the upper bits are zero.
    assign w_rx8      = 8'(rx_command);
    assign w_cmd8     = 8'(r_cmd);
    assign w_rx_ok    = (rx_command == CMD_W'(w_rx8)) && cmd_known(w_rx8);
    assign w_cmd_fits = (r_cmd == CMD_W'(w_cmd8));
    assign w_region   = cmd_region(w_cmd8);

    assign w_abort    = (r_state == S_DECODE) && w_cmd_fits && (w_cmd8 == CMD_ABORT);
    assign w_full     = (r_pending == PEND_W'(NUM_CORES));
    assign w_accept   = (r_state == S_HASH) && !w_full;
    assign w_dispatch = ((r_pending != '0) || w_accept) && (|(~w_running)) && !w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_address    <= '0;
            r_final_addr <= '0;
            r_load       <= 1'b0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_load      <= 1'b0;
            r_cmd_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_notify) begin
                        r_cmd       <= rx_command;
                        r_cmd_error <= !w_rx_ok;
                        r_state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_cmd_fits && w_region.valid) begin
                        r_address    <= ADDR_W'(w_region.start_addr);
                        r_final_addr <= ADDR_W'(w_region.final_addr);
                        r_state      <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (rx_notify) begin
                        r_load  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD:  r_state <= S_CHECK;
                S_CHECK: r_state <= (r_address == r_final_addr) ? S_HASH : S_INCR;
                S_INCR: begin
                    r_address <= r_address + ADDR_W'(1);
                    r_state   <= S_WAIT;
                end
                S_HASH: begin
                    r_cmd_error <= w_full;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_pending <= '0;
        end else if (w_accept && !w_dispatch) begin
            r_pending <= r_pending + PEND_W'(1);
        end else if (!w_accept && w_dispatch) begin
            r_pending <= r_pending - PEND_W'(1);
        end
    end

    always_comb begin
        w_first_idle = '0;
        w_first_done = '0;
        w_nonce_idx  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!w_running[i]) begin
                w_first_idle = NUM_CORES'(1) << i;
            end
            if (w_done[i]) begin
                w_first_done = NUM_CORES'(1) << i;
                w_nonce_idx  = NC_W'(i);
            end
        end
    end

    assign w_start_sel = w_dispatch ? w_first_idle : '0;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        core_slot u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_start      (w_start_sel[g]),
            .i_done       (hash_done[g]),
            .i_clear      (w_first_done[g]),
            .o_running    (w_running[g]),
            .o_done       (w_done[g]),
            .o_start_hash (start_hash[g])
        );
    end

    assign address     = r_address;
    assign load        = r_load;
    assign cmd_error   = r_cmd_error;
    assign nonce_ready = |w_done;
    assign nonce_core  = w_nonce_idx;
    assign busy        = (|w_running) || (r_pending != '0);

endmodule

// File: tb/tb_main_dispatch_ctrl.sv
// Scoreboard bench for main_dispatch_ctrl: expected loads, starts, nonces and errors are queued
// with the stimulus and consumed by a negedge monitor as the DUT produces them.
module tb_main_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_notify;
    logic [7:0] rx_command;
    logic [1:0] hash_done;
    logic [6:0] address;
    logic       load;
    logic [1:0] start_hash;
    logic       nonce_ready;
    logic [0:0] nonce_core;
    logic       cmd_error;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_load[$];
    int exp_start[$];
    int exp_nonce[$];
    int exp_err_addr[$];
    int last_load_cyc = 0;
    int last_start_cyc = 0;
    int last_nonce_cyc = 0;
    int prev_nonce_cyc = 0;

    main_dispatch_ctrl #(.ADDR_W(7), .NUM_CORES(2), .CMD_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_notify   (rx_notify),
        .rx_command  (rx_command),
        .hash_done   (hash_done),
        .address     (address),
        .load        (load),
        .start_hash  (start_hash),
        .nonce_ready (nonce_ready),
        .nonce_core  (nonce_core),
        .cmd_error   (cmd_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Any event with nothing queued is compared against -1 and so always fails.
    always @(negedge clk) begin
        int e;
        if (load === 1'b1) begin
            e = (exp_load.size() > 0) ? exp_load.pop_front() : -1;
            check_val("load_addr", int'(address), e);
            last_load_cyc = cyc;
        end
        for (int i = 0; i < 2; i++) begin
            if (start_hash[i] === 1'b1) begin
                e = (exp_start.size() > 0) ? exp_start.pop_front() : -1;
                check_val("start_core", i, e);
                last_start_cyc = cyc;
            end
        end
        if (nonce_ready === 1'b1) begin
            e = (exp_nonce.size() > 0) ? exp_nonce.pop_front() : -1;
            check_val("nonce_core", int'(nonce_core), e);
            prev_nonce_cyc = last_nonce_cyc;
            last_nonce_cyc = cyc;
        end
        if (cmd_error === 1'b1) begin
            e = (exp_err_addr.size() > 0) ? exp_err_addr.pop_front() : -1;
            check_val("err_addr", int'(address), e);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        @(posedge clk);
        #1 rx_notify = 1'b1;
        rx_command = b;
        @(posedge clk);
        #1 rx_notify = 1'b0;
    endtask

    task automatic load_cmd(input logic [7:0] cmd, input int n);
        pulse(cmd);
        for (int k = 0; k < n; k++) begin
            pulse(8'($urandom_range(0, 255)));
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic done_pulse(input logic [1:0] m);
        @(posedge clk);
        #1 hash_done = m;
        @(posedge clk);
        #1 hash_done = 2'b00;
    endtask

    task automatic drain(input string tag);
        check_val({tag, "_load_left"},  exp_load.size(),     0);
        check_val({tag, "_start_left"}, exp_start.size(),    0);
        check_val({tag, "_nonce_left"}, exp_nonce.size(),    0);
        check_val({tag, "_err_left"},   exp_err_addr.size(), 0);
    endtask

    task automatic push_r5_loads();
        for (int a = 76; a <= 79; a++) exp_load.push_back(a);
    endtask

    initial begin
        rst        = 1'b1;
        rx_notify  = 1'b0;
        rx_command = 8'h00;
        hash_done  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_address", int'(address), 0);
        check_val("rst_load", int'(load), 0);
        check_val("rst_start", int'(start_hash), 0);
        check_val("rst_nonce", int'(nonce_ready), 0);
        check_val("rst_err", int'(cmd_error), 0);
        check_val("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Region 0..3, then one-cycle dispatch latency and its completion.
        for (int a = 0; a < 4; a++) exp_load.push_back(a);
        exp_start.push_back(0);
        load_cmd(8'h02, 4);
        idle(4);
        check_val("hash_latency", last_start_cyc - last_load_cyc, 3);
        exp_nonce.push_back(0);
        done_pulse(2'b01);
        idle(3);
        drain("r0");
        check_val("r0_busy", int'(busy), 0);

        // Invalid commands leave the address alone.
        exp_err_addr.push_back(3);
        pulse(8'h03);
        idle(1);
        exp_err_addr.push_back(3);
        pulse(8'h00);
        idle(3);
        drain("bad");
        check_val("bad_address", int'(address), 3);

        // Three requests on two cores: third waits until core 1 frees up.
        for (int k = 0; k < 3; k++) begin
            push_r5_loads();
            if (k < 2) exp_start.push_back(k);
            load_cmd(8'h40, 4);
        end
        idle(4);
        drain("q3");
        check_val("q3_busy", int'(busy), 1);
        exp_nonce.push_back(1);
        exp_start.push_back(1);
        done_pulse(2'b10);
        idle(3);
        check_val("free_redispatch", last_start_cyc - last_nonce_cyc, 1);
        drain("q3b");

        // Simultaneous completions reported on consecutive cycles.
        exp_nonce.push_back(0);
        exp_nonce.push_back(1);
        done_pulse(2'b11);
        idle(3);
        check_val("nonce_consec", last_nonce_cyc - prev_nonce_cyc, 1);
        drain("dual");
        check_val("dual_busy", int'(busy), 0);

        // Reset during WAIT of a region 12..43 load while core 0 is hashing.
        push_r5_loads();
        exp_start.push_back(0);
        load_cmd(8'h40, 4);
        idle(3);
        exp_load.push_back(12);
        pulse(8'h10);
        pulse(8'h5A);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("wait_address", int'(address), 13);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_address", int'(address), 0);
        check_val("rst_mid_busy", int'(busy), 0);
        done_pulse(2'b01);
        idle(3);
        drain("rst_mid");

        // Fill the pending counter, overflow it, then abort.
        for (int k = 0; k < 5; k++) begin
            push_r5_loads();
            if (k < 2) exp_start.push_back(k);
            if (k == 4) exp_err_addr.push_back(79);
            load_cmd(8'h40, 4);
        end
        idle(3);
        drain("full");
        pulse(8'h80);
        idle(3);
        check_val("abort_busy", int'(busy), 1);
        exp_nonce.push_back(0);
        done_pulse(2'b01);
        idle(4);
        check_val("abort_busy_one", int'(busy), 1);
        exp_nonce.push_back(1);
        done_pulse(2'b10);
        idle(3);
        check_val("abort_busy_none", int'(busy), 0);
        drain("abort");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/main_dispatch_ctrl.md
MAIN_DISPATCH_CTRL -- requirements
Module: main_dispatch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning memory address width; ADDR_W SHALL be at least 7.
REQ-002 SHALL have parameter NUM_CORES, default 2, meaning number of hash cores served (1..8).
REQ-003 SHALL have parameter CMD_W, default 8, meaning command byte width.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rx_notify  in  1  one-cycle pulse: new byte received.
REQ-007 rx_command  in  CMD_W  received command byte; valid when rx_notify is high.
REQ-008 hash_done  in  NUM_CORES  per-core completion pulse.
REQ-009 address  out  ADDR_W  write address to block memory.
REQ-010 load  out  1  one-cycle write strobe at address.
REQ-011 start_hash  out  NUM_CORES  per-core one-cycle start pulse.
REQ-012 nonce_ready  out  1  one-cycle pulse: a core has finished.
REQ-013 nonce_core  out  max(1,clog2(NUM_CORES))  index of the finishing core; valid with nonce_ready.
REQ-014 cmd_error  out  1  one-cycle pulse: invalid command, or hash request dropped.
REQ-015 busy  out  1  high when any core is running or any request is pending.

Function
REQ-016 The data FSM SHALL use states IDLE, DECODE, WAIT, LOAD, CHECK, INCR, HASH.
REQ-017 Data FSM transitions SHALL be:
- IDLE -> DECODE on rx_notify.
- DECODE -> WAIT on a valid load command; otherwise DECODE -> IDLE.
- WAIT -> LOAD on rx_notify.
- LOAD -> CHECK.
- CHECK -> HASH if address == final; otherwise CHECK -> INCR.
- INCR -> WAIT.
- HASH -> IDLE.
REQ-018 The command byte SHALL be latched on the rx_notify cycle that causes IDLE -> DECODE.
REQ-019 Load commands SHALL set the region (start, final) as follows:
- 0x01: 0..79
- 0x02: 0..3
- 0x04: 4..7
- 0x08: 8..11
- 0x10: 12..43
- 0x20: 44..75
- 0x40: 76..79
REQ-020 Command 0x80 SHALL be abort: it clears the pending count, leaves running cores untouched, and returns the FSM to IDLE without asserting cmd_error.
REQ-021 Any other command value SHALL pulse cmd_error in the DECODE cycle and leave address and final unchanged.
REQ-022 load SHALL be high only in LOAD; address SHALL be stable from WAIT through CHECK.
REQ-023 address SHALL increment by exactly 1 in INCR; ADDR_W wider than 7 SHALL zero-extend the region constants.
REQ-024 An rx_notify arriving in DECODE, LOAD, CHECK, INCR or HASH SHALL be ignored.
REQ-025 HASH SHALL increment the pending counter (range 0..NUM_CORES). If the counter is already at NUM_CORES, the request is dropped and cmd_error pulses.
REQ-026 Dispatch: each cycle with pending > 0 and at least one idle core:
- the lowest-index idle core receives start_hash the next cycle;
- that core becomes running;
- pending decrements.
REQ-027 A HASH increment and a dispatch decrement in the same cycle SHALL leave pending unchanged.
REQ-028 Latency: HASH state in cycle n -> start_hash in cycle n+1 when a core is idle.
REQ-029 hash_done on a running core SHALL set that core's done flag and return the core to idle in the same cycle; hash_done on an idle core SHALL be ignored.
REQ-030 Each cycle, the lowest-index set done flag SHALL produce nonce_ready with nonce_core = that index, and that flag is cleared. Multiple simultaneous dones are reported on consecutive cycles; none is lost.
REQ-031 A core freed by hash_done SHALL be dispatchable in the following cycle.

Reset
REQ-032 While rst is high at a clock edge, the block SHALL reset to:
- data FSM in IDLE;
- address = 0, final = 0;
- pending = 0;
- all cores idle, all done flags clear;
- all outputs low.
REQ-033 Reset mid-load or mid-hash SHALL abandon the operation; hash_done arriving afterwards SHALL be ignored.

Structure
REQ-034 A shared package dispatch_pkg SHALL hold the data-FSM enum, the command constants, and the region start/final table.
REQ-035 One sub-module, core_slot, SHALL be instantiated NUM_CORES times; it holds a core's running and done flags plus its start-pulse register.

Verification
REQ-036 Command 0x02 then 4 data bytes -> load at addresses 0,1,2,3, then start_hash[0] one cycle after HASH.
REQ-037 Command 0x03, then 0x00 -> cmd_error pulse each time, address unchanged, no load.
REQ-038 NUM_CORES=2, three back-to-back 0x40 loads -> cores 0 and 1 started, third request pending. hash_done[1] -> nonce_ready with nonce_core=1, then start_hash[1] the next cycle.
REQ-039 hash_done=2'b11 in the same cycle -> nonce_ready on two consecutive cycles with nonce_core 0 then 1.
REQ-040 rst asserted during WAIT of a 0x10 load -> next cycle IDLE, address 0; a later stray hash_done -> no nonce_ready.
REQ-041 Pending full (NUM_CORES) with all cores running, another HASH -> cmd_error. Then 0x80 -> pending 0; busy stays high until both cores are done.
